// File: rtl/pin_driver_pkg.sv
// Shared encodings for the SMI control-pin drivers.
// The hold state machine has only two states: idle, or counting down a hold.
package pin_driver_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

endpackage

// File: rtl/pin_driver.sv
// Drives one output pin from a synchronous level request.
// Every output level is held for a programmable minimum time before it may change again.
module pin_driver
    import pin_driver_pkg::*;
#(
    parameter int   HOLD_W      = 8,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_b,
    input  logic              i_enable,
    input  logic              i_data_in,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    output logic              o_data_out,
    output logic              o_edge,
    output logic              o_busy,
    output logic              o_pending
);

    localparam logic [HOLD_W-1:0] ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [HOLD_W-1:0] count, count_nx;
    logic [HOLD_W-1:0] hold_eff;
    logic              out_nx;
    logic              edge_nx;
    logic              differ;

    // A hold of zero would let the pin toggle with no dwell at all, so it is clamped to one.
    assign hold_eff = (i_hold_cycles == '0) ? ONE : i_hold_cycles;
    assign differ   = (i_data_in != o_data_out);

    always_comb begin
        state_nx = state;
        count_nx = count;
        out_nx   = o_data_out;
        edge_nx  = 1'b0;
        if (!i_enable) begin
            // Disable overrides any running hold; the pin is parked immediately.
            state_nx = STABLE;
            count_nx = '0;
            out_nx   = RESET_LEVEL;
            edge_nx  = (o_data_out != RESET_LEVEL);
        end else begin
            case (state)
                STABLE: begin
                    if (differ) begin
                        out_nx   = ~o_data_out;
                        edge_nx  = 1'b1;
                        count_nx = hold_eff;
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (count == ONE) begin
                        if (differ) begin
                            out_nx   = ~o_data_out;
                            edge_nx  = 1'b1;
                            count_nx = hold_eff;
                        end else begin
                            count_nx = '0;
                            state_nx = STABLE;
                        end
                    end else begin
                        count_nx = count - ONE;
                    end
                end
                default: begin
                    state_nx = STABLE;
                    count_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state      <= STABLE;
            count      <= '0;
            o_data_out <= RESET_LEVEL;
            o_edge     <= 1'b0;
            o_busy     <= 1'b0;
            o_pending  <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            o_data_out <= out_nx;
            o_edge     <= edge_nx;
            o_busy     <= (state_nx == HOLD);
            o_pending  <= i_enable && differ;
        end
    end

endmodule
